// File: rtl/cv32e40x_rf_write_merger.sv
// Merges in-order WB writes and buffered EXT (eXtension) results onto the two RF write ports.
// Latency: WB 0 cycles; EXT >=1 cycle, or 0 with CV32E40X_RF_MERGE_BYPASS_EN defined and the FIFO empty.
// Backpressure: WB never stalls; EXT ready while FIFO not full; the head yields to WB on collisions.
module cv32e40x_rf_write_merger #(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid_i,
  input  logic [4:0]       wb_addr_i,
  input  logic [31:0]      wb_data_i,
  input  logic             ext_valid_i,
  output logic             ext_ready_o,
  input  logic             ext_dual_i,
  input  logic [4:0]       ext_addr_i,
  input  logic [1:0][31:0] ext_data_i,
  output logic [1:0][4:0]  waddr_o,
  output logic [1:0][31:0] wdata_o,
  output logic [1:0]       we_o,
  output logic             dualwrite_o,
  output logic             pending_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             dual;
    logic [4:0]       addr;
    logic [1:0][31:0] data;
  } ext_entry_t;

  ext_entry_t      fifo_q [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic            wr_en;
  logic            drain;
  logic            cand_vld;
  ext_entry_t      cand;
  ext_entry_t      in_entry;

  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign ext_ready_o = !rst && !full;
  assign push        = ext_valid_i && ext_ready_o;
  assign in_entry    = '{dual: ext_dual_i, addr: ext_addr_i, data: ext_data_i};

`ifdef CV32E40X_RF_MERGE_BYPASS_EN
  // An empty FIFO lets the incoming result compete for the ports directly.
  assign cand_vld = !empty || push;
  assign cand     = empty ? in_entry : fifo_q[rd_ptr];
`else
  assign cand_vld = !empty;
  assign cand     = fifo_q[rd_ptr];
`endif

  always_comb begin
    drain = 1'b0;
    if (cand_vld && !rst) begin
      if (cand.dual) drain = !wb_valid_i;
      else           drain = !(wb_valid_i && (wb_addr_i == cand.addr));
    end
  end

  // A bypassed result drains without ever occupying a slot.
  assign pop   = drain && !empty;
  assign wr_en = push && !(drain && empty);

  always_comb begin
    waddr_o = '0;
    wdata_o = '0;
    we_o    = '0;
    if (!rst && wb_valid_i) begin
      we_o[0]    = 1'b1;
      waddr_o[0] = wb_addr_i;
      wdata_o[0] = wb_data_i;
    end
    if (drain) begin
      we_o[1]    = 1'b1;
      wdata_o[1] = cand.dual ? cand.data[1] : cand.data[0];
      waddr_o[1] = cand.dual ? {cand.addr[4:1], 1'b1} : cand.addr;
      if (cand.dual) begin
        we_o[0]    = 1'b1;
        waddr_o[0] = {cand.addr[4:1], 1'b0};
        wdata_o[0] = cand.data[0];
      end
    end
    // x0 is hardwired; suppress and clear any port aimed at it.
    for (int i = 0; i < 2; i++) begin
      if (waddr_o[i] == 5'd0) begin
        we_o[i]    = 1'b0;
        wdata_o[i] = '0;
      end
    end
  end

  assign dualwrite_o = we_o[1];
  assign pending_o   = !rst && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        fifo_q[wr_ptr] <= in_entry;
        wr_ptr         <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_cv32e40x_rf_write_merger.sv
// Bench for cv32e40x_rf_write_merger (default build): per-cycle control vectors plus an EXT write scoreboard.
module tb_cv32e40x_rf_write_merger;

  logic             clk = 1'b0;
  logic             rst;
  logic             wb_valid_i;
  logic [4:0]       wb_addr_i;
  logic [31:0]      wb_data_i;
  logic             ext_valid_i;
  logic             ext_ready_o;
  logic             ext_dual_i;
  logic [4:0]       ext_addr_i;
  logic [1:0][31:0] ext_data_i;
  logic [1:0][4:0]  waddr_o;
  logic [1:0][31:0] wdata_o;
  logic [1:0]       we_o;
  logic             dualwrite_o;
  logic             pending_o;

  always #5 clk = ~clk;

  cv32e40x_rf_write_merger #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .ext_valid_i(ext_valid_i), .ext_ready_o(ext_ready_o), .ext_dual_i(ext_dual_i),
    .ext_addr_i(ext_addr_i), .ext_data_i(ext_data_i),
    .waddr_o(waddr_o), .wdata_o(wdata_o), .we_o(we_o),
    .dualwrite_o(dualwrite_o), .pending_o(pending_o)
  );

  typedef struct {
    logic        rst, wbv;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        ev, ed;
    logic [4:0]  ea;
    logic [31:0] d0, d1;
    logic        rdy, pend;
    logic [1:0]  we;
    logic        dw;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  vec_t tv[$];
  wr_t  exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic void add(logic r, logic wbv, logic [4:0] wba, logic [31:0] wbd,
                              logic ev, logic ed, logic [4:0] ea, logic [31:0] d0, logic [31:0] d1,
                              logic rdy, logic pend, logic [1:0] we, logic dw);
    vec_t v;
    v.rst = r; v.wbv = wbv; v.wba = wba; v.wbd = wbd;
    v.ev = ev; v.ed = ed; v.ea = ea; v.d0 = d0; v.d1 = d1;
    v.rdy = rdy; v.pend = pend; v.we = we; v.dw = dw;
    tv.push_back(v);
  endfunction

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endfunction

  task automatic drive(logic r, logic wbv, logic [4:0] wba, logic [31:0] wbd,
                       logic ev, logic ed, logic [4:0] ea, logic [31:0] d0, logic [31:0] d1);
    rst = r; wb_valid_i = wbv; wb_addr_i = wba; wb_data_i = wbd;
    ext_valid_i = ev; ext_dual_i = ed; ext_addr_i = ea;
    ext_data_i[0] = d0; ext_data_i[1] = d1;
  endtask

  // Expected register-file writes an accepted EXT result will eventually make, x0 excluded.
  task automatic expect_ext(logic ed, logic [4:0] ea, logic [31:0] d0, logic [31:0] d1);
    wr_t w;
    if (ed) begin
      w.a = {ea[4:1], 1'b0}; w.d = d0;
      if (w.a != 5'd0) exp_q.push_back(w);
      w.a = {ea[4:1], 1'b1}; w.d = d1;
      exp_q.push_back(w);
    end else if (ea != 5'd0) begin
      w.a = ea; w.d = d0;
      exp_q.push_back(w);
    end
  endtask

  task automatic ext_port(int p);
    wr_t w;
    if (exp_q.size() == 0) begin
      chk($sformatf("ext_unexpected_p%0d", p), {we_o[p], waddr_o[p]}, 6'd0);
    end else begin
      w = exp_q.pop_front();
      chk($sformatf("ext_wr_p%0d", p), {waddr_o[p], wdata_o[p]}, {w.a, w.d});
    end
  endtask

  task automatic monitor();
    if (rst) begin
      exp_q.delete();
    end else begin
      if (wb_valid_i && wb_addr_i != 5'd0)
        chk("wb_wr", {we_o[0], waddr_o[0], wdata_o[0]}, {1'b1, wb_addr_i, wb_data_i});
      if (we_o[0] && !wb_valid_i) ext_port(0);
      if (we_o[1]) ext_port(1);
    end
  endtask

  initial begin
    int  cyc;
    vec_t v;
    //   rst wbv wba    wbd           ev ed ea     d0       d1        rdy pend we     dw
    add(1, 0, 5'd0,  32'h0,        1, 0, 5'd3,  32'h9,   32'h0,    0, 0, 2'b00, 0); // held in reset
    add(1, 0, 5'd0,  32'h0,        1, 0, 5'd3,  32'h9,   32'h0,    0, 0, 2'b00, 0);
    add(0, 0, 5'd0,  32'h0,        0, 0, 5'd0,  32'h0,   32'h0,    1, 0, 2'b00, 0);
    add(0, 1, 5'd5,  32'hA5A5A5A5, 0, 0, 5'd0,  32'h0,   32'h0,    1, 0, 2'b01, 0); // WB zero latency
    add(0, 0, 5'd0,  32'h0,        1, 0, 5'd7,  32'h1234, 32'h0,   1, 0, 2'b00, 0); // EXT single x7
    add(0, 0, 5'd0,  32'h0,        0, 0, 5'd0,  32'h0,   32'h0,    1, 1, 2'b10, 1);
    add(0, 0, 5'd0,  32'h0,        0, 0, 5'd0,  32'h0,   32'h0,    1, 0, 2'b00, 0);
    add(0, 1, 5'd1,  32'h11,       1, 1, 5'd11, 32'h1,   32'h2,    1, 0, 2'b01, 0); // dual held by WB
    add(0, 1, 5'd2,  32'h22,       0, 0, 5'd0,  32'h0,   32'h0,    1, 1, 2'b01, 0);
    add(0, 1, 5'd3,  32'h33,       0, 0, 5'd0,  32'h0,   32'h0,    1, 1, 2'b01, 0);
    add(0, 0, 5'd0,  32'h0,        0, 0, 5'd0,  32'h0,   32'h0,    1, 1, 2'b11, 1);
    add(0, 1, 5'd4,  32'h44,       1, 1, 5'd12, 32'hA,   32'hB,    1, 0, 2'b01, 0); // fill to full
    add(0, 1, 5'd4,  32'h45,       1, 1, 5'd14, 32'hC,   32'hD,    1, 1, 2'b01, 0);
    add(0, 1, 5'd4,  32'h46,       1, 1, 5'd16, 32'hE,   32'hF,    0, 1, 2'b01, 0);
    add(0, 0, 5'd0,  32'h0,        1, 1, 5'd16, 32'hE,   32'hF,    0, 1, 2'b11, 1); // pop does not raise ready
    add(0, 0, 5'd0,  32'h0,        1, 1, 5'd16, 32'hE,   32'hF,    1, 1, 2'b11, 1);
    add(0, 0, 5'd0,  32'h0,        0, 0, 5'd0,  32'h0,   32'h0,    1, 1, 2'b11, 1);
    add(0, 0, 5'd0,  32'h0,        1, 0, 5'd8,  32'h88,  32'h0,    1, 0, 2'b00, 0); // collision on x8
    add(0, 1, 5'd8,  32'h80,       0, 0, 5'd0,  32'h0,   32'h0,    1, 1, 2'b01, 0);
    add(0, 0, 5'd0,  32'h0,        0, 0, 5'd0,  32'h0,   32'h0,    1, 1, 2'b10, 1);
    add(0, 0, 5'd0,  32'h0,        1, 0, 5'd0,  32'h99,  32'h0,    1, 0, 2'b00, 0); // single to x0
    add(0, 0, 5'd0,  32'h0,        0, 0, 5'd0,  32'h0,   32'h0,    1, 1, 2'b00, 0);
    add(0, 0, 5'd0,  32'h0,        0, 0, 5'd0,  32'h0,   32'h0,    1, 0, 2'b00, 0);
    add(0, 0, 5'd0,  32'h0,        1, 1, 5'd0,  32'h5,   32'h6,    1, 0, 2'b00, 0); // dual x0/x1
    add(0, 0, 5'd0,  32'h0,        0, 0, 5'd0,  32'h0,   32'h0,    1, 1, 2'b10, 1);
    add(0, 0, 5'd0,  32'h0,        0, 0, 5'd0,  32'h0,   32'h0,    1, 0, 2'b00, 0);
    add(0, 1, 5'd9,  32'h90,       1, 0, 5'd9,  32'h91,  32'h0,    1, 0, 2'b01, 0); // discarded by reset
    add(0, 1, 5'd9,  32'h92,       0, 0, 5'd0,  32'h0,   32'h0,    1, 1, 2'b01, 0);
    add(1, 0, 5'd0,  32'h0,        0, 0, 5'd0,  32'h0,   32'h0,    0, 0, 2'b00, 0);
    add(0, 0, 5'd0,  32'h0,        0, 0, 5'd0,  32'h0,   32'h0,    1, 0, 2'b00, 0);
    add(0, 0, 5'd0,  32'h0,        1, 0, 5'd20, 32'h20,  32'h0,    1, 0, 2'b00, 0); // no collision
    add(0, 1, 5'd21, 32'h21,       0, 0, 5'd0,  32'h0,   32'h0,    1, 1, 2'b11, 1);
    add(0, 0, 5'd0,  32'h0,        0, 0, 5'd0,  32'h0,   32'h0,    1, 0, 2'b00, 0);

    drive(1, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0, 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < tv.size(); i++) begin
      v = tv[i];
      drive(v.rst, v.wbv, v.wba, v.wbd, v.ev, v.ed, v.ea, v.d0, v.d1);
      @(negedge clk);
      chk($sformatf("row%0d_ctl", i), {ext_ready_o, pending_o, we_o, dualwrite_o},
          {v.rdy, v.pend, v.we, v.dw});
      monitor();
      if (!v.rst && v.ev && v.rdy) expect_ext(v.ed, v.ea, v.d0, v.d1);
      @(posedge clk); #1;
    end

    // Queue two results behind WB traffic, then let them drain with a bounded wait.
    drive(0, 1, 5'd2, 32'h200, 1, 1, 5'd24, 32'h240, 32'h250);
    @(negedge clk);
    chk("seq_rdy0", {31'd0, ext_ready_o}, 1);
    monitor();
    expect_ext(1, 5'd24, 32'h240, 32'h250);
    @(posedge clk); #1;
    drive(0, 1, 5'd2, 32'h201, 1, 0, 5'd26, 32'h260, 32'h0);
    @(negedge clk);
    chk("seq_rdy1", {31'd0, ext_ready_o}, 1);
    monitor();
    expect_ext(0, 5'd26, 32'h260, 32'h0);
    @(posedge clk); #1;
    drive(0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0, 32'h0);
    cyc = 0;
    @(negedge clk);
    while (pending_o && cyc < 8) begin
      monitor();
      @(posedge clk); #1;
      @(negedge clk);
      cyc++;
    end
    chk("seq_drain_pending", {63'd0, pending_o}, 0);
    chk("seq_drain_empty", 64'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
